// File: rtl/fir_tap_sequencer_if.sv
// Sequencer <-> tap MAC link: accumulator clear, product enable, operand pair and settled result.
// master = sequencer side, slave = MAC side.
interface fir_tap_sequencer_if #(
  parameter int COEF_W = 16,
  parameter int DATA_W = 24,
  parameter int ACC_W  = 32
);
  logic                     tap_acc_clr;
  logic                     tap_data_en;
  logic signed [COEF_W-1:0] tap_coefficients;
  logic signed [DATA_W-1:0] tap_aud_data;
  logic signed [ACC_W-1:0]  tap_result;

  modport master (
    output tap_acc_clr,
    output tap_data_en,
    output tap_coefficients,
    output tap_aud_data,
    input  tap_result
  );

  modport slave (
    input  tap_acc_clr,
    input  tap_data_en,
    input  tap_coefficients,
    input  tap_aud_data,
    output tap_result
  );
endinterface

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: circular delay line + coefficient bank, one MAC convolution per audio sample.
// Define FIR_SAT_EN to clamp the captured result to the signed DATA_W range.
//
// state | meaning
// IDLE  | waiting for audio_en, sample written to delay line on accept
// CLEAR | accumulator clear pulse to the MAC
// RUN   | one coefficient/sample pair per cycle, k = 0..NUM_TAPS-1
// DRAIN | MAC_LAT cycles for the MAC pipeline to settle
// DONE  | fir_data_valid strobe, write pointer advance
module fir_tap_sequencer #(
  parameter int NUM_TAPS = 32,
  parameter int COEF_W   = 16,
  parameter int DATA_W   = 24,
  parameter int ACC_W    = 32,
  parameter int MAC_LAT  = 3
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          audio_en,
  input  logic signed [DATA_W-1:0]      aud_data_in,
  input  logic                          coef_wr_en,
  input  logic [$clog2(NUM_TAPS)-1:0]   coef_wr_addr,
  input  logic signed [COEF_W-1:0]      coef_wr_data,
  fir_tap_sequencer_if.master           mac,
  output logic signed [ACC_W-1:0]       fir_data_out,
  output logic                          fir_data_valid,
  output logic                          busy,
  output logic                          overrun
);
  localparam int PTR_W = $clog2(NUM_TAPS);
  localparam int DRN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

  state_t                   state_q, state_nxt;
  logic [PTR_W-1:0]         wr_ptr_q;
  logic [PTR_W-1:0]         tap_q, tap_nxt;
  logic [PTR_W-1:0]         rd_idx;
  logic [DRN_W-1:0]         drain_q, drain_nxt;
  logic signed [DATA_W-1:0] delay_mem [NUM_TAPS];
  logic signed [COEF_W-1:0] coef_mem  [NUM_TAPS];
  logic signed [COEF_W-1:0] coef_q;
  logic signed [DATA_W-1:0] aud_q;
  logic signed [ACC_W-1:0]  result_cap;
  logic                     sample_accept;

  assign sample_accept = audio_en && (state_q == IDLE);
  assign rd_idx        = wr_ptr_q - tap_nxt;

  always_comb begin
    state_nxt = state_q;
    tap_nxt   = tap_q;
    drain_nxt = drain_q;
    case (state_q)
      IDLE:  if (audio_en) state_nxt = CLEAR;
      CLEAR: begin
        state_nxt = RUN;
        tap_nxt   = '0;
      end
      RUN: begin
        if (tap_q == PTR_W'(NUM_TAPS - 1)) begin
          state_nxt = DRAIN;
          drain_nxt = DRN_W'(MAC_LAT - 1);
        end else begin
          tap_nxt = tap_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == '0) state_nxt = DONE;
        else               drain_nxt = drain_q - 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  always_comb begin
    result_cap = mac.tap_result;
    if (mac.tap_result > SAT_MAX)      result_cap = SAT_MAX;
    else if (mac.tap_result < SAT_MIN) result_cap = SAT_MIN;
  end
`else
  always_comb begin
    result_cap = mac.tap_result;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      tap_q        <= '0;
      drain_q      <= '0;
      wr_ptr_q     <= '0;
      coef_q       <= '0;
      aud_q        <= '0;
      fir_data_out <= '0;
      overrun      <= 1'b0;
    end else begin
      state_q <= state_nxt;
      tap_q   <= tap_nxt;
      drain_q <= drain_nxt;
      overrun <= audio_en && (state_q != IDLE);
      if (state_q == DONE) wr_ptr_q <= wr_ptr_q + 1'b1;
      // operands are loaded on the edge entering each RUN cycle; a coefficient written on that same edge is not yet visible
      if (state_nxt == RUN) begin
        coef_q <= coef_mem[tap_nxt];
        aud_q  <= delay_mem[rd_idx];
      end
      if (state_q == DRAIN && drain_q == '0) fir_data_out <= result_cap;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_TAPS; i++) delay_mem[i] <= '0;
    end else if (sample_accept) begin
      delay_mem[wr_ptr_q] <= aud_data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_TAPS; i++) coef_mem[i] <= '0;
    end else if (coef_wr_en) begin
      coef_mem[coef_wr_addr] <= coef_wr_data;
    end
  end

  assign mac.tap_acc_clr      = (state_q == CLEAR);
  assign mac.tap_data_en      = (state_q == RUN);
  assign mac.tap_coefficients = coef_q;
  assign mac.tap_aud_data     = aud_q;
  assign fir_data_valid       = (state_q == DONE);
  assign busy                 = (state_q != IDLE);
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: behavioural MAC, convolution reference model, queue scoreboard.
module tb_fir_tap_sequencer;
  localparam int NT = 32, CW = 16, DW = 24, AW = 32, ML = 3;
  localparam int PASS_LEN = 38;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 audio_en = 1'b0;
  logic signed [DW-1:0] aud_data_in = '0;
  logic                 coef_wr_en = 1'b0;
  logic [4:0]           coef_wr_addr = '0;
  logic signed [CW-1:0] coef_wr_data = '0;
  logic signed [AW-1:0] fir_data_out;
  logic                 fir_data_valid, busy, overrun;

  fir_tap_sequencer_if #(.COEF_W(CW), .DATA_W(DW), .ACC_W(AW)) mac_if ();

  fir_tap_sequencer #(.NUM_TAPS(NT), .COEF_W(CW), .DATA_W(DW), .ACC_W(AW), .MAC_LAT(ML)) dut (
    .clk(clk), .reset_n(reset_n), .audio_en(audio_en), .aud_data_in(aud_data_in),
    .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
    .mac(mac_if), .fir_data_out(fir_data_out), .fir_data_valid(fir_data_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // behavioural MAC: accumulate on enable, two extra pipeline stages -> settled 3 cycles after last enable
  logic signed [AW-1:0] acc = '0, pipe1 = '0, pipe2 = '0;
  logic signed [39:0]   prod;
  logic                 ovr_en = 1'b0;
  logic signed [AW-1:0] ovr_val = '0;
  always @(posedge clk) begin
    prod = mac_if.tap_coefficients * mac_if.tap_aud_data;
    if (mac_if.tap_acc_clr)      acc <= '0;
    else if (mac_if.tap_data_en) acc <= acc + prod[AW-1:0];
    pipe1 <= acc;
    pipe2 <= pipe1;
  end
  assign mac_if.tap_result = ovr_en ? ovr_val : pipe2;

  typedef struct {int cyc; longint a; longint b;} exp_t;
  exp_t q_tap[$];
  exp_t q_out[$];
  int   q_clr[$];
  int   q_ovr[$];

  int  ref_delay[NT];
  int  ref_coef[NT];
  int  ref_ptr = 0;
  int  last_e = 0;
  bit  have_pass = 0;
  int  cyc = 0;
  int  total = 0, bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic longint sat(input longint raw);
`ifdef FIR_SAT_EN
    if (raw > 64'sd8388607)  return 64'sd8388607;
    if (raw < -64'sd8388608) return -64'sd8388608;
`endif
    return raw;
  endfunction

  task automatic send_sample(input int v);
    longint sum;
    longint raw;
    int idx;
    @(negedge clk);
    audio_en    = 1'b1;
    aud_data_in = v[DW-1:0];
    if (!have_pass || cyc - last_e >= PASS_LEN) begin
      ref_delay[ref_ptr] = v;
      q_clr.push_back(cyc + 1);
      sum = 0;
      for (int k = 0; k < NT; k++) begin
        idx = (ref_ptr - k + NT) % NT;
        q_tap.push_back('{cyc + 2 + k, longint'(ref_coef[k]), longint'(ref_delay[idx])});
        sum += longint'(ref_coef[k]) * longint'(ref_delay[idx]);
      end
      raw = ovr_en ? longint'(ovr_val) : longint'(int'(sum));
      q_out.push_back('{cyc + 37, sat(raw), 0});
      ref_ptr   = (ref_ptr + 1) % NT;
      last_e    = cyc;
      have_pass = 1;
    end else begin
      q_ovr.push_back(cyc + 1);
    end
    @(negedge clk);
    audio_en = 1'b0;
  endtask

  task automatic send_gap(input int v, input int gap);
    send_sample(v);
    repeat (gap - 2) @(negedge clk);
  endtask

  task automatic wait_idle();
    while (have_pass && cyc < last_e + PASS_LEN) @(negedge clk);
  endtask

  task automatic wr_coef(input int a, input int v);
    @(negedge clk);
    coef_wr_en   = 1'b1;
    coef_wr_addr = a[4:0];
    coef_wr_data = v[CW-1:0];
    ref_coef[a]  = v;
    @(negedge clk);
    coef_wr_en = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_clr"},   mac_if.tap_acc_clr, 0);
    chk({tag, "_en"},    mac_if.tap_data_en, 0);
    chk({tag, "_coef"},  mac_if.tap_coefficients, 0);
    chk({tag, "_aud"},   mac_if.tap_aud_data, 0);
    chk({tag, "_out"},   fir_data_out, 0);
    chk({tag, "_valid"}, fir_data_valid, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_ovr"},   overrun, 0);
  endtask

  // monitor: one sample per cycle, #1 after the active edge
  always @(posedge clk) begin
    exp_t t;
    bit   exp_busy;
    #1;
    cyc++;
    exp_busy = have_pass && (cyc > last_e) && (cyc <= last_e + PASS_LEN - 1);
    chk("busy", busy, exp_busy);

    if (q_clr.size() > 0 && q_clr[0] == cyc) begin
      void'(q_clr.pop_front());
      chk("acc_clr", mac_if.tap_acc_clr, 1);
      chk("clr_en_exclusive", mac_if.tap_data_en, 0);
    end else if (mac_if.tap_acc_clr) chk("acc_clr_spurious", mac_if.tap_acc_clr, 0);

    if (q_tap.size() > 0 && q_tap[0].cyc == cyc) begin
      t = q_tap.pop_front();
      chk("data_en", mac_if.tap_data_en, 1);
      chk("tap_coef", longint'(mac_if.tap_coefficients), t.a);
      chk("tap_aud", longint'(mac_if.tap_aud_data), t.b);
    end else if (mac_if.tap_data_en) chk("data_en_spurious", mac_if.tap_data_en, 0);

    if (q_out.size() > 0 && q_out[0].cyc == cyc) begin
      t = q_out.pop_front();
      chk("fir_valid", fir_data_valid, 1);
      chk("fir_out", longint'(fir_data_out), t.a);
    end else if (fir_data_valid) chk("fir_valid_spurious", fir_data_valid, 0);

    if (q_ovr.size() > 0 && q_ovr[0] == cyc) begin
      void'(q_ovr.pop_front());
      chk("overrun", overrun, 1);
    end else if (overrun) chk("overrun_spurious", overrun, 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    chk_all_zero("rst_hold");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("rst_rel");

    // first pass with cleared delay line, then impulse response with coef[k]=k+1
    for (int k = 0; k < NT; k++) wr_coef(k, k + 1);
    send_gap(32'h100, 40);
    for (int n = 1; n < NT; n++) send_gap(0, 40);
    wait_idle();

    // wrap-around: ramp 1..40
    for (int i = 1; i <= 40; i++) send_gap(i, 40);
    wait_idle();

    // overrun mid-pass, then boundary at DONE (dropped) and first IDLE cycle (accepted)
    send_gap(1000, 10);
    send_gap(-77777, 40);
    send_gap(555, 40);
    send_gap(-321, 37);
    send_gap(999, 40);
    send_gap(4242, 38);
    send_gap(-1, 40);
    wait_idle();

    // random coefficients and samples, gaps straddle the pass length
    for (int k = 0; k < NT; k++) wr_coef(k, int'($urandom_range(0, 65535)) - 32768);
    for (int i = 0; i < 30; i++) begin
      send_gap(int'($urandom_range(0, 24'hFFFFFF)) - 8388608, int'($urandom_range(12, 60)));
    end
    wait_idle();

    // saturation corners via forced MAC result
    ovr_en = 1'b1;
    ovr_val = 32'sh0090_0000; send_sample(7); wait_idle();
    ovr_val = 32'shFF00_0000; send_sample(8); wait_idle();
    ovr_val = 32'sh007F_FFFF; send_sample(9); wait_idle();
    ovr_val = -32'sd5;        send_sample(10); wait_idle();
    ovr_en = 1'b0;

    // mid-operation reset at cycle 20
    send_sample(12345);
    repeat (19) @(negedge clk);
    reset_n = 1'b0;
    q_tap.delete(); q_out.delete(); q_clr.delete(); q_ovr.delete();
    for (int k = 0; k < NT; k++) begin ref_delay[k] = 0; ref_coef[k] = 0; end
    ref_ptr = 0; have_pass = 0;
    #1;
    chk_all_zero("midrst");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NT; k++) wr_coef(k, int'($urandom_range(0, 200)) - 100);
    send_gap(3000, 40);
    send_gap(-4000, 40);
    wait_idle();
    repeat (5) @(negedge clk);

    chk("pending_expect", q_tap.size() + q_out.size() + q_clr.size() + q_ovr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
